fp_acc_seq: RTL and testbench

FP_ACC_SEQ -- requirements
Module: fp_acc_seq

---
 rtl/ibex_pkg.sv | 27 ++
 rtl/fp_res_class.sv | 25 ++
 rtl/fp_acc_seq.sv | 143 ++++++++++++++
 tb/tb_fp_acc_seq.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types and constants for the bfloat16 accumulator sequencer.
//   fp_alu_op_e     - operation requested from the external add/sub stage
//   fp_acc_state_e  - sequencer FSM states
//   FP_BF16_QNAN    - canonical bfloat16 quiet NaN
//   FP_BF16_EXP_MAX - all-ones bfloat16 exponent (Inf/NaN)
//   bf16_flush      - replaces a subnormal value by a zero of the same sign
package ibex_pkg;

    typedef enum logic [1:0] {
        FP_ALU_ADD = 2'd0,
        FP_ALU_SUB = 2'd1
    } fp_alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fp_acc_state_e;

    localparam logic [15:0] FP_BF16_QNAN    = 16'h7FC0;
    localparam logic [7:0]  FP_BF16_EXP_MAX = 8'hFF;

    function automatic logic [15:0] bf16_flush(input logic [15:0] val, input logic flush);
        return flush ? {val[15], 15'h0000} : val;
    endfunction

endpackage

// File: rtl/fp_res_class.sv
// fp_res_class: classifies a bfloat16 value by exponent and mantissa.
//   data_i : bfloat16 value to classify
//   is_nan : exponent all ones, mantissa non-zero
//   is_inf : exponent all ones, mantissa zero
//   is_sub : exponent zero, mantissa non-zero
module fp_res_class
    import ibex_pkg::*;
(
    input  logic [15:0] data_i,
    output logic        is_nan,
    output logic        is_inf,
    output logic        is_sub
);

    logic [7:0] exp_s;
    logic [6:0] man_s;

    assign exp_s  = data_i[14:7];
    assign man_s  = data_i[6:0];

    assign is_nan = (exp_s == FP_BF16_EXP_MAX) && (man_s != 7'h00);
    assign is_inf = (exp_s == FP_BF16_EXP_MAX) && (man_s == 7'h00);
    assign is_sub = (exp_s == 8'h00) && (man_s != 7'h00);

endmodule

// File: rtl/fp_acc_seq.sv
// fp_acc_seq: sequences a bfloat16 stream through an external combinational
// add/sub stage, accumulating count_i elements onto init_i.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   start_i, op_i, init_i, count_i : job launch (sampled in IDLE only)
//   in_valid_i/in_data_i/in_ready_o : element stream, one element per beat
//   as_a_o/as_b_o/as_op_o/as_c_i   : link to the external add/sub stage
//   res_valid_o/res_data_o/res_ready_i : result handshake
//   busy_o, nan_o, inf_o         : busy indicator, sticky exception flags
// Build option: define FP_ACC_FLUSH_EN to store subnormal stage results as
// signed zero; otherwise stage results are stored unmodified.
module fp_acc_seq
    import ibex_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  fp_alu_op_e       op_i,
    input  logic [15:0]      init_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             in_valid_i,
    input  logic [15:0]      in_data_i,
    output logic             in_ready_o,
    output logic [15:0]      as_a_o,
    output logic [15:0]      as_b_o,
    output fp_alu_op_e       as_op_o,
    input  logic [15:0]      as_c_i,
    output logic             res_valid_o,
    output logic [15:0]      res_data_o,
    input  logic             res_ready_i,
    output logic             busy_o,
    output logic             nan_o,
    output logic             inf_o
);

`ifdef FP_ACC_FLUSH_EN
    localparam logic FLUSH_EN = 1'b1;
`else
    localparam logic FLUSH_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    fp_acc_state_e    state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    fp_alu_op_e       op_q, op_d;
    logic             nan_q, nan_d;
    logic             inf_q, inf_d;

    logic             is_nan_s, is_inf_s, is_sub_s;
    logic             beat_s;
    logic [15:0]      store_s;

    fp_res_class u_class (
        .data_i (as_c_i),
        .is_nan (is_nan_s),
        .is_inf (is_inf_s),
        .is_sub (is_sub_s)
    );

    // The flush function is always in the path; FLUSH_EN folds it away when off.
    assign store_s = bf16_flush(as_c_i, is_sub_s & FLUSH_EN);
    assign beat_s  = in_valid_i & (state_q == RUN);

    // Next-state, accumulator, remaining-count and flag update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        op_d    = op_q;
        nan_d   = nan_q;
        inf_d   = inf_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d   = init_i;
                    rem_d   = count_i;
                    op_d    = op_i;
                    nan_d   = 1'b0;
                    inf_d   = 1'b0;
                    state_d = (count_i == CNT_ZERO) ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // rem is at least one here, so the decrement cannot wrap.
                if (beat_s) begin
                    acc_d   = store_s;
                    rem_d   = rem_q - CNT_ONE;
                    nan_d   = nan_q | is_nan_s;
                    inf_d   = inf_q | is_inf_s;
                    state_d = (rem_q == CNT_ONE) ? DONE : RUN;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= 16'h0000;
            rem_q   <= CNT_ZERO;
            op_q    <= FP_ALU_ADD;
            nan_q   <= 1'b0;
            inf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            nan_q   <= nan_d;
            inf_q   <= inf_d;
        end
    end

    assign as_a_o      = acc_q;
    assign as_b_o      = in_data_i;
    assign as_op_o     = op_q;
    assign in_ready_o  = (state_q == RUN);
    assign busy_o      = (state_q != IDLE);
    assign res_valid_o = (state_q == DONE);
    assign res_data_o  = (state_q == DONE) ? acc_q : 16'h0000;
    assign nan_o       = nan_q;
    assign inf_o       = inf_q;

endmodule

// File: tb/tb_fp_acc_seq.sv
// tb_fp_acc_seq: randomized + directed bench for fp_acc_seq. The external
// add/sub stage is a behavioural real-arithmetic model; expected results are
// folded from the element lists and queued at start, and a monitor compares
// them whenever the DUT presents a result.
module tb_fp_acc_seq;
    import ibex_pkg::*;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    fp_alu_op_e       op = FP_ALU_ADD;
    logic [15:0]      init = 16'h0000;
    logic [CNT_W-1:0] count = '0;
    logic             in_valid = 1'b0;
    logic [15:0]      in_data = 16'h0000;
    logic             in_ready;
    logic [15:0]      as_a, as_b, as_c;
    fp_alu_op_e       as_op;
    logic             res_valid;
    logic [15:0]      res_data;
    logic             res_ready = 1'b1;
    logic             busy, nan, inf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] res;
        logic        nan;
        logic        inf;
    } exp_t;
    exp_t sb_q[$];

    fp_acc_seq #(.CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .init_i(init),
        .count_i(count), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(in_ready), .as_a_o(as_a), .as_b_o(as_b), .as_op_o(as_op),
        .as_c_i(as_c), .res_valid_o(res_valid), .res_data_o(res_data),
        .res_ready_i(res_ready), .busy_o(busy), .nan_o(nan), .inf_o(inf)
    );

    always #5 clk = ~clk;

    function automatic logic f_nan(input logic [15:0] v);
        return (v[14:7] == 8'hFF) && (v[6:0] != 7'h00);
    endfunction

    function automatic logic f_inf(input logic [15:0] v);
        return (v[14:7] == 8'hFF) && (v[6:0] == 7'h00);
    endfunction

    function automatic real to_real(input logic [15:0] v);
        real val;
        if (v[14:7] == 8'h00) return 0.0;
        val = (1.0 + real'(int'(v[6:0])) / 128.0) * (2.0 ** (real'(int'(v[14:7])) - 127.0));
        return v[15] ? -val : val;
    endfunction

    function automatic logic [15:0] from_real(input real r);
        logic sgn;
        real  mag;
        int   e;
        int   m;
        sgn = (r < 0.0);
        mag = sgn ? -r : r;
        if (mag == 0.0) return 16'h0000;
        e = 0;
        while (mag >= 2.0 && e < 300) begin mag = mag / 2.0; e++; end
        while (mag < 1.0 && e > -300) begin mag = mag * 2.0; e--; end
        if (e + 127 >= 255) return {sgn, 8'hFF, 7'h00};
        if (e + 127 <= 0) return {sgn, 15'h0000};
        m = $rtoi((mag - 1.0) * 128.0);
        return {sgn, 8'(e + 127), 7'(m)};
    endfunction

    // Behavioural bfloat16 add/sub (truncating, no subnormal results).
    function automatic logic [15:0] bf_add(input logic [15:0] a, input logic [15:0] b,
                                           input fp_alu_op_e o);
        logic [15:0] bb;
        bb = (o == FP_ALU_SUB) ? {~b[15], b[14:0]} : b;
        if (f_nan(a) || f_nan(bb)) return 16'h7FC0;
        if (f_inf(a) && f_inf(bb)) return (a[15] == bb[15]) ? a : 16'h7FC0;
        if (f_inf(a)) return a;
        if (f_inf(bb)) return bb;
        return from_real(to_real(a) + to_real(bb));
    endfunction

    assign as_c = bf_add(as_a, as_b, as_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Result monitor: every presented result must match the queue head.
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h required=none", res_data);
            end else begin
                check("res_data", {16'h0, res_data}, {16'h0, sb_q[0].res});
                if (res_ready) begin
                    check("nan_flag", {31'h0, nan}, {31'h0, sb_q[0].nan});
                    check("inf_flag", {31'h0, inf}, {31'h0, sb_q[0].inf});
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 1000) begin tick(); k++; end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout actual=busy required=idle");
        end
    endtask

    function automatic logic [15:0] rand_elem();
        logic [7:0] ex;
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) return 16'h7F80;
        if (sel == 1) return 16'hFF80;
        ex = 8'($urandom_range(120, 134));
        return {1'($urandom_range(0, 1)), ex, 7'($urandom_range(0, 127))};
    endfunction

    // Computes the expected result from the element list, queues it, launches the job.
    task automatic start_txn(input fp_alu_op_e o, input logic [15:0] iv, input logic [15:0] el[$]);
        exp_t e;
        e.res = iv;
        e.nan = 1'b0;
        e.inf = 1'b0;
        foreach (el[i]) begin
            e.res = bf_add(e.res, el[i], o);
            e.nan = e.nan | f_nan(e.res);
            e.inf = e.inf | f_inf(e.res);
        end
        sb_q.push_back(e);
        start = 1'b1;
        op    = o;
        init  = iv;
        count = CNT_W'(el.size());
        tick();
        start = 1'b0;
        op    = (o == FP_ALU_ADD) ? FP_ALU_SUB : FP_ALU_ADD;
        init  = 16'($urandom);
    endtask

    task automatic feed(input logic [15:0] el[$], input bit gaps);
        foreach (el[i]) begin
            bit got = 1'b0;
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 1'b0;
                    in_data  = 16'($urandom);
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data  = el[i];
            for (int k = 0; k < 200 && !got; k++) begin
                @(negedge clk);
                if (in_ready) got = 1'b1;
                @(posedge clk);
                #1;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL feed_timeout actual=no_ready required=ready");
            end
        end
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] el[$];
        logic [15:0] one[$];
        logic [15:0] two[$];

        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready",  {31'h0, in_ready},  32'h0);
        check("rst_busy",      {31'h0, busy},      32'h0);
        check("rst_res_valid", {31'h0, res_valid}, 32'h0);
        check("rst_res_data",  {16'h0, res_data},  32'h0);
        check("rst_flags",     {30'h0, nan, inf},  32'h0);
        rst = 1'b0;
        tick();

        // 1.0 + 1.0 + 1.0 onto 0.0, back to back
        el = '{16'h3F80, 16'h3F80, 16'h3F80};
        start_txn(FP_ALU_ADD, 16'h0000, el);
        check("t1_ready_in_run", {31'h0, in_ready}, 32'h1);
        check("t1_as_op", {30'h0, as_op}, {30'h0, FP_ALU_ADD});
        feed(el, 1'b0);
        check("t1_valid_after_last", {31'h0, res_valid}, 32'h1);
        check("t1_res", {16'h0, res_data}, 32'h4040);
        check("t1_flags", {30'h0, nan, inf}, 32'h0);
        wait_idle();

        // 4.0 - 1.0
        el = '{16'h3F80};
        start_txn(FP_ALU_SUB, 16'h4080, el);
        check("t2_as_op", {30'h0, as_op}, {30'h0, FP_ALU_SUB});
        feed(el, 1'b0);
        check("t2_res", {16'h0, res_data}, 32'h4040);
        wait_idle();

        // zero-length job
        el = {};
        start_txn(FP_ALU_ADD, 16'h4000, el);
        check("t3_done", {31'h0, res_valid}, 32'h1);
        check("t3_no_ready", {31'h0, in_ready}, 32'h0);
        check("t3_res", {16'h0, res_data}, 32'h4000);
        wait_idle();

        // +Inf then -Inf
        el  = '{16'h7F80, 16'hFF80};
        one = '{16'h7F80};
        two = '{16'hFF80};
        start_txn(FP_ALU_ADD, 16'h0000, el);
        feed(one, 1'b0);
        check("t4_inf_beat1", {31'h0, inf}, 32'h1);
        check("t4_nan_beat1", {31'h0, nan}, 32'h0);
        feed(two, 1'b0);
        check("t4_nan_beat2", {31'h0, nan}, 32'h1);
        check("t4_res", {16'h0, res_data}, 32'h7FC0);
        wait_idle();

        // gaps, result stall of 5 cycles, stray start during the stall
        res_ready = 1'b0;
        el = '{rand_elem(), rand_elem(), rand_elem(), rand_elem()};
        start_txn(FP_ALU_ADD, 16'h3F00, el);
        feed(el, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check("t5_stall_valid", {31'h0, res_valid}, 32'h1);
            start = (c == 2);
            init  = 16'h1234;
            count = CNT_W'(32'd5);
            tick();
        end
        start = 1'b0;
        res_ready = 1'b1;
        wait_idle();
        tick();
        check("t5_start_ignored", {31'h0, busy}, 32'h0);

        // reset after one of three beats
        el  = '{16'h3F80, 16'h3F80, 16'h3F80};
        one = '{16'h3F80};
        start_txn(FP_ALU_ADD, 16'h0000, el);
        feed(one, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h3F80;
        tick();
        rst = 1'b0;
        void'(sb_q.pop_back());
        check("t6_in_ready", {31'h0, in_ready},  32'h0);
        check("t6_busy",     {31'h0, busy},      32'h0);
        check("t6_valid",    {31'h0, res_valid}, 32'h0);
        check("t6_res_data", {16'h0, res_data},  32'h0);
        check("t6_flags",    {30'h0, nan, inf},  32'h0);
        check("t6_acc",      {16'h0, as_a},      32'h0);
        tick();
        check("t6_discard", {31'h0, busy}, 32'h0);
        in_valid = 1'b0;
        start_txn(FP_ALU_ADD, 16'h0000, el);
        feed(el, 1'b1);
        check("t6_fresh_res", {16'h0, res_data}, 32'h4040);
        wait_idle();

        // maximum count
        el = {};
        for (int i = 0; i < 255; i++) el.push_back(16'h3F80);
        start_txn(FP_ALU_ADD, 16'h0000, el);
        feed(el, 1'b0);
        check("t7_max_count_res", {16'h0, res_data}, 32'h437F);
        wait_idle();

        // randomized jobs
        for (int t = 0; t < 25; t++) begin
            fp_alu_op_e o;
            int n;
            o = ($urandom_range(0, 1) == 1) ? FP_ALU_SUB : FP_ALU_ADD;
            n = $urandom_range(0, 6);
            el = {};
            for (int i = 0; i < n; i++) el.push_back(rand_elem());
            res_ready = ($urandom_range(0, 3) != 0);
            start_txn(o, rand_elem(), el);
            feed(el, 1'b1);
            repeat ($urandom_range(0, 3)) tick();
            res_ready = 1'b1;
            wait_idle();
        end

        tick();
        check("sb_drained", sb_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
